// File: rtl/gn_mdl_rst_seq.sv
// Bench reset sequencer: synchronizes rst_n and releases staged per-domain resets in order.
// Optional GN_MDL_RST_SEQ_LOG_EN compiles in $display logging of releases, completion and requests.
module gn_mdl_rst_seq #(
  parameter int P_NUM_STAGES = 3,
  parameter int P_HOLD_CYC   = 16,
  parameter int P_STAGE_GAP  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_rst_req,
  output logic [P_NUM_STAGES-1:0] stage_rst_n,
  output logic                    busy,
  output logic                    seq_done,
  output logic                    sw_rst_drop,
  output logic [1:0]              dbg_state
);

  localparam int LP_MAX_CYC = (P_HOLD_CYC > P_STAGE_GAP) ? P_HOLD_CYC : P_STAGE_GAP;
  localparam int CW = $clog2(LP_MAX_CYC + 1);
  localparam int IW = $clog2(P_NUM_STAGES) + 1;

  if (P_NUM_STAGES < 1 || P_NUM_STAGES > 16 || P_HOLD_CYC < 1 || P_STAGE_GAP < 1) begin : g_param_chk
    $fatal(1, "gn_mdl_rst_seq: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_sync;
  logic                    w_sync;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_nxt;
  logic [P_NUM_STAGES-1:0] r_stage;
  logic [P_NUM_STAGES-1:0] w_stage_nxt;
  logic                    r_drop;

  // Asynchronous assert, synchronous deassert after two rising edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], 1'b1};
  end
  assign w_sync = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HOLD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage;
    if (w_sync) begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == CW'(P_HOLD_CYC - 1)) begin
            w_stage_nxt[0] = 1'b1;
            w_cnt_nxt      = '0;
            w_idx_nxt      = IW'(1);
            w_state_nxt    = (P_NUM_STAGES == 1) ? S_DONE : S_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (r_cnt == CW'(P_STAGE_GAP - 1)) begin
            for (int i = 0; i < P_NUM_STAGES; i++) begin
              if (IW'(i) == r_idx) w_stage_nxt[i] = 1'b1;
            end
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + IW'(1);
            if (r_idx == IW'(P_NUM_STAGES - 1)) w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (sw_rst_req) begin
            w_stage_nxt = '0;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end
        default: w_state_nxt = S_HOLD;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_DONE);
    seq_done  = (r_state == S_DONE);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_stage <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_stage <= w_stage_nxt;
      // Any request seen while a sequence is running is discarded, not queued.
      r_drop  <= sw_rst_req && (r_state != S_DONE);
    end
  end

  assign stage_rst_n = r_stage;
  assign sw_rst_drop = r_drop;

`ifdef GN_MDL_RST_SEQ_LOG_EN
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < P_NUM_STAGES; i++) begin
        if (w_stage_nxt[i] && !r_stage[i]) $display("%0t %m: stage %0d released", $time, i);
      end
      if (w_state_nxt == S_DONE && r_state != S_DONE) $display("%0t %m: seq_done", $time);
      if (r_state == S_DONE && sw_rst_req) $display("%0t %m: sw_rst_req accepted", $time);
      if (r_state != S_DONE && sw_rst_req) $display("%0t %m: sw_rst_req dropped", $time);
    end
  end
`endif

endmodule

// File: tb/tb_gn_mdl_rst_seq.sv
// Bench for gn_mdl_rst_seq: default instance plus a one-stage, one-cycle-hold corner instance.
module tb_gn_mdl_rst_seq;

  localparam int H = 16;
  localparam int G = 4;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_req;
  logic       sw1_req;
  logic [2:0] stage_rst_n;
  logic       busy;
  logic       seq_done;
  logic       sw_rst_drop;
  logic [1:0] dbg_state;
  logic [0:0] stage1_rst_n;
  logic       busy1;
  logic       seq_done1;
  logic       sw_rst_drop1;
  logic [1:0] dbg_state1;

  logic [5:0] exp_q[$];
  logic [3:0] exp1_q[$];
  int n_checks;
  int n_errors;

  gn_mdl_rst_seq #(.P_NUM_STAGES(3), .P_HOLD_CYC(H), .P_STAGE_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .stage_rst_n(stage_rst_n), .busy(busy), .seq_done(seq_done),
    .sw_rst_drop(sw_rst_drop), .dbg_state(dbg_state)
  );

  gn_mdl_rst_seq #(.P_NUM_STAGES(1), .P_HOLD_CYC(1), .P_STAGE_GAP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw1_req),
    .stage_rst_n(stage1_rst_n), .busy(busy1), .seq_done(seq_done1),
    .sw_rst_drop(sw_rst_drop1), .dbg_state(dbg_state1)
  );

  // 125 MHz; rising edges at multiples of 8 ns.
  initial clk = 1'b1;
  always #4 clk = ~clk;

  // Expected {stage[2:0], busy, seq_done, drop}; stage k is released at edge base+H+k*G.
  function automatic logic [5:0] mk(int e, int base, bit drp);
    logic [2:0] s;
    for (int k = 0; k < 3; k++) s[k] = (e >= base + H + k * G);
    return {s, ~(&s), &s, drp};
  endfunction

  // Corner instance: one stage, hold of one cycle, released at edge 3 after rst_n rises.
  function automatic logic [3:0] mk1(int e);
    logic s;
    s = (e >= 3);
    return {s, ~s, s, 1'b0};
  endfunction

  task automatic chk6(string tag, logic [5:0] obs, logic [5:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk4(string tag, logic [3:0] obs, logic [3:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step(string tag);
    logic [5:0] e6;
    logic [3:0] e4;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e6 = exp_q.pop_front();
      chk6(tag, {stage_rst_n, busy, seq_done, sw_rst_drop}, e6);
    end
    if (exp1_q.size() != 0) begin
      e4 = exp1_q.pop_front();
      chk4({tag, "_corner"}, {stage1_rst_n, busy1, seq_done1, sw_rst_drop1}, e4);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    sw1_req    = 1'b0;

    #50;
    chk6("reset_state", {stage_rst_n, busy, seq_done, sw_rst_drop}, 6'b000_1_0_0);
    chk4("reset_state_corner", {stage1_rst_n, busy1, seq_done1, sw_rst_drop1}, 4'b0_1_0_0);
    #50;
    rst_n = 1'b1;

    // Power-on, interrupted after edge 20.
    for (int e = 1; e <= 20; e++) begin
      exp_q.push_back(mk(e, 2, 1'b0));
      if (e <= 5) exp1_q.push_back(mk1(e));
      step("power_on");
    end

    // Mid-sequence asynchronous reset, 3 ns long.
    rst_n = 1'b0;
    #1;
    chk6("async_reset", {stage_rst_n, busy, seq_done, sw_rst_drop}, 6'b000_1_0_0);
    chk4("async_reset_corner", {stage1_rst_n, busy1, seq_done1, sw_rst_drop1}, 4'b0_1_0_0);
    #2;
    rst_n = 1'b1;

    // Replay from scratch, with a request pulsed at the stage1 release edge.
    for (int e = 1; e <= 32; e++) begin
      exp_q.push_back(mk(e, 2, e == 22));
      step("replay_drop");
      if (e == 21) sw_rst_req = 1'b1;
      if (e == 22) sw_rst_req = 1'b0;
    end

    // One-cycle software re-reset accepted in DONE at edge R (e=0).
    sw_rst_req = 1'b1;
    for (int e = 0; e <= 28; e++) begin
      exp_q.push_back(mk(e, 0, 1'b0));
      step("sw_rerst");
      if (e == 0) sw_rst_req = 1'b0;
    end

    // Request held for three edges: accepted once, then dropped on each busy cycle.
    sw_rst_req = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      exp_q.push_back(mk(e, 0, (e == 1) || (e == 2)));
      step("sw_held");
      if (e == 2) sw_rst_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gn_mdl_rst_seq.md
Name: gn_mdl_rst_seq

Overview:
Simulation reset sequencer model that sits directly downstream of the bench clock generator model and consumes its clk output. It synchronizes an asynchronous active-low bench reset and releases a set of staged per-domain resets in a fixed order with programmable hold and gap times. It also supports software-requested re-reset from the bench. It is the single source of reset for DUT subsystems in block- and top-level benches.

Parameters:
P_NUM_STAGES, 3, number of staged reset outputs (1..16)
P_HOLD_CYC, 16, cycles from synchronized reset release to stage 0 release (>=1)
P_STAGE_GAP, 4, cycles between consecutive stage releases (>=1)

Ports:
clk  input  1  clock from the clock generator model
rst_n  input  1  asynchronous active-low bench reset
sw_rst_req  input  1  software re-reset request, sampled on rising clk
stage_rst_n  output  P_NUM_STAGES  staged active-low resets; bit 0 is released first
busy  output  1  sequence in progress
seq_done  output  1  all stages released
sw_rst_drop  output  1  one-cycle pulse when a request is ignored

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- rst_n=0, applied asynchronously:
  - stage_rst_n=0 (all bits), busy=1, seq_done=0, sw_rst_drop=0.
  - Synchronizer flops, counter and stage index cleared; FSM forced to HOLD.
- Synchronizer:
  - 2-flop chain: asynchronous assert, synchronous deassert.
  - Internal rst_sync_n rises on the 2nd rising edge after rst_n rises.
  - The FSM advances only while rst_sync_n=1.
- FSM states: HOLD, RELEASE, DONE.
  - HOLD: cnt increments each cycle. When cnt reaches P_HOLD_CYC-1: stage_rst_n[0]<=1, cnt<=0, idx<=1. Then go to RELEASE, or to DONE if P_NUM_STAGES==1.
  - RELEASE: cnt increments each cycle. When cnt reaches P_STAGE_GAP-1: stage_rst_n[idx]<=1, cnt<=0, idx<=idx+1. Go to DONE after idx==P_NUM_STAGES-1 is released.
  - DONE: busy=0 and seq_done=1, registered on the same edge as the last stage release.
  - DONE with sw_rst_req=1: on that edge stage_rst_n<=0, busy<=1, seq_done<=0, cnt<=0, go to HOLD.
- Timing: counting edges from rst_n rising (edge 1 = first rising edge), stage k rises at edge 2+P_HOLD_CYC+k*P_STAGE_GAP. With defaults: stage0 at edge 18, stage1 at 22, stage2 at 26; seq_done at 26.
- Software re-reset timing: after a request accepted at edge R, stage k rises at edge R+P_HOLD_CYC+k*P_STAGE_GAP.
- Requests while busy=1 are ignored and not queued; sw_rst_drop=1 for the following cycle. A request held high across the DONE edge is accepted once. If the request is still high while busy, each such cycle pulses sw_rst_drop.
- Released stages never re-assert except via rst_n or an accepted sw_rst_req.
- rst_n asserted mid-sequence: immediate asynchronous return to the reset values above; the sequence restarts from scratch on deassert.
- Counter width: $clog2 of max(P_HOLD_CYC, P_STAGE_GAP)+1. Index width: $clog2(P_NUM_STAGES)+1.
- Elaboration check: $fatal if any parameter is out of range.

Optional Feature:
GN_MDL_RST_SEQ_LOG_EN
- Defined: $display with $time and %m on every stage release, on seq_done rise, on accepted sw_rst_req, and on every drop.
- Undefined: no display code is compiled.
- Output behaviour is identical either way.

Test Plan:
- Power-on: 125 MHz clock, rst_n low 100 ns then high (defaults) -> stage_rst_n 000->001 at edge 18, 011 at edge 22, 111 at edge 26; seq_done=1 and busy=0 at edge 26.
- Mid-sequence reset: drop rst_n at edge 20 for 3 ns -> stage_rst_n=000 and busy=1 immediately, without waiting for a clk edge; full sequence replays with stage0 at edge 18 after re-release.
- Software re-reset: 1-cycle sw_rst_req in DONE at edge R -> stage_rst_n=000 at R; 001 at R+16, 011 at R+20, 111 at R+24.
- Drop: sw_rst_req pulsed at stage1 release while busy -> sw_rst_drop=1 for exactly 1 cycle; the sequence is unchanged; no restart after DONE.
- Parameter corner: P_NUM_STAGES=1, P_HOLD_CYC=1 -> stage_rst_n[0] and seq_done rise at edge 3 after rst_n rises.
- Log build: compile with +define+GN_MDL_RST_SEQ_LOG_EN -> exactly P_NUM_STAGES+1 messages per power-on sequence; the waveform matches the non-log build.
